// File: rtl/game_sequencer_if.sv
// Signal bundle between game_sequencer and the surrounding game blocks.
// The sequencer uses the slave modport; whatever drives tick/start/collide uses the master modport.
interface game_sequencer_if;
    logic       tick;
    logic       start;
    logic       collide;
    logic [1:0] state;
    logic       run;
    logic       score_en;
    logic       score_clr;
    logic [1:0] lives;
    logic       blink;
    logic       game_over;

    modport master (
        output tick, start, collide,
        input  state, run, score_en, score_clr, lives, blink, game_over
    );

    modport slave (
        input  tick, start, collide,
        output state, run, score_en, score_clr, lives, blink, game_over
    );
endinterface

// File: rtl/game_sequencer.sv
// Dodge-game flow controller: idle/play/hit-recovery/over sequencing, lives and player blink.
// Define GAME_SEQ_PAUSE_EN to let start toggle a pause while playing; otherwise start is ignored in PLAY.
module game_sequencer #(
    parameter int unsigned LIVES_INIT = 3,
    parameter int unsigned HIT_TICKS  = 32,
    parameter int unsigned BLINK_DIV  = 4
) (
    input logic             clk,
    input logic             clr,
    game_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    localparam logic [1:0] LIVES_LD  = 2'(LIVES_INIT);
    localparam logic [7:0] HIT_LD    = 8'(HIT_TICKS - 1);
    localparam logic [7:0] BLINK_TOP = 8'(BLINK_DIV - 1);

    state_t     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [7:0] hit_cnt_q, hit_cnt_d;
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_q, blink_d;
    logic       paused_q, paused_d;
    logic       score_clr_q, score_clr_d;
    logic       run_q, score_en_q, game_over_q;
    logic       hit_now;

    // A collision only counts on a game tick and never while paused.
    assign hit_now = bus.tick && bus.collide && !paused_q;

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        hit_cnt_d   = hit_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = 1'b1;
        paused_d    = 1'b0;
        score_clr_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                lives_d = LIVES_LD;
                if (bus.start) begin
                    state_d     = S_PLAY;
                    score_clr_d = 1'b1;
                end
            end

            S_PLAY: begin
                paused_d = paused_q;
                if (hit_now) begin
                    paused_d = 1'b0;
                    if (lives_q > 2'd1) begin
                        state_d     = S_HIT;
                        lives_d     = lives_q - 2'd1;
                        hit_cnt_d   = HIT_LD;
                        blink_cnt_d = '0;
                    end else begin
                        state_d = S_OVER;
                        lives_d = '0;
                    end
                end
`ifdef GAME_SEQ_PAUSE_EN
                else if (bus.start) begin
                    paused_d = !paused_q;
                end
`endif
            end

            S_HIT: begin
                blink_d = blink_q;
                if (bus.tick) begin
                    if (hit_cnt_q == '0) begin
                        state_d = S_PLAY;
                        blink_d = 1'b1;
                    end else begin
                        hit_cnt_d = hit_cnt_q - 8'd1;
                        if (blink_cnt_q == BLINK_TOP) begin
                            blink_cnt_d = '0;
                            blink_d     = !blink_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 8'd1;
                        end
                    end
                end
            end

            S_OVER: begin
                lives_d = '0;
                if (bus.start) begin
                    state_d     = S_PLAY;
                    lives_d     = LIVES_LD;
                    score_clr_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                lives_d = LIVES_LD;
            end
        endcase
    end

    // Status outputs are derived from the next state so they change on the same edge as state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            lives_q     <= LIVES_LD;
            hit_cnt_q   <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
            paused_q    <= 1'b0;
            score_clr_q <= 1'b0;
            run_q       <= 1'b0;
            score_en_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            hit_cnt_q   <= hit_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            paused_q    <= paused_d;
            score_clr_q <= score_clr_d;
            run_q       <= (state_d == S_PLAY) && !paused_d;
            score_en_q  <= (state_d == S_PLAY) && !paused_d;
            game_over_q <= (state_d == S_OVER);
        end
    end

    assign bus.state     = state_q;
    assign bus.run       = run_q;
    assign bus.score_en  = score_en_q;
    assign bus.score_clr = score_clr_q;
    assign bus.lives     = lives_q;
    assign bus.blink     = blink_q;
    assign bus.game_over = game_over_q;

endmodule
